pc_redirect_controller: RTL and testbench

- Owns the program counter; sequences next-PC selection among sequential PC+4, taken-branch target, J/JAL jump target and JR register target.
- Sits between IF and the hazard/branch-resolution logic: EX-stage branch/JR resolution and ID-stage jump decode request redirects; hazard unit supplies Stall.
- Latches redirects that arrive during a stall and applies them on release; drives the IF/ID flush.

---
 rtl/pc_ctrl_pkg.sv | 32 +++
 rtl/pc_target_calc.sv | 51 +++++
 rtl/pc_redirect_controller.sv | 119 +++++++++++
 tb/tb_pc_redirect_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared definitions for the PC redirect controller:
//   state_t           - controller state (RUN / PEND)
//   SRC_*             - RedirectSrc encoding (0 none, 1 branch, 2 jr, 3 jump)
//   DEFAULT_RESET_PC  - default fetch address after reset
//   src_rank()        - priority rank of a redirect source (higher wins)
package pc_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JR     = 2'd2;
  localparam logic [1:0] SRC_JUMP   = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // EX-stage redirects belong to older instructions, so they outrank the
  // ID-stage jump; branch beats jr because branch is resolved first in EX.
  function automatic logic [1:0] src_rank(input logic [1:0] src);
    case (src)
      SRC_BRANCH: src_rank = 2'd3;
      SRC_JR:     src_rank = 2'd2;
      SRC_JUMP:   src_rank = 2'd1;
      default:    src_rank = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc
// Combinational target computation and priority selection.
// Inputs : pc, branch_req/branch_pc/branch_imm, jr_req/jr_target,
//          jump_req/jump_pc/jump_index
// Outputs: seq_pc      - pc + 4 (wraps mod 2^32)
//          live_src    - winning request this cycle (SRC_* encoding)
//          live_target - target address of the winning request
module pc_target_calc
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_req,
  input  logic [31:0] branch_pc,
  input  logic [15:0] branch_imm,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        jump_req,
  input  logic [31:0] jump_pc,
  input  logic [25:0] jump_index,
  output logic [31:0] seq_pc,
  output logic [1:0]  live_src,
  output logic [31:0] live_target
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_jump_pc_bits;

  assign seq_pc        = pc + 32'd4;
  assign branch_target = branch_pc + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_target   = {jump_pc[31:28], jump_index, 2'b00};

  // Only the region bits of the jump instruction's PC+4 form the target.
  assign unused_jump_pc_bits = ^jump_pc[27:0];

  always_comb begin
    live_src    = SRC_NONE;
    live_target = seq_pc;
    if (branch_req) begin
      live_src    = SRC_BRANCH;
      live_target = branch_target;
    end else if (jr_req) begin
      live_src    = SRC_JR;
      live_target = jr_target;
    end else if (jump_req) begin
      live_src    = SRC_JUMP;
      live_target = jump_target;
    end
  end

endmodule

// File: rtl/pc_redirect_controller.sv
// pc_redirect_controller
// Owns the program counter and selects the next fetch address among PC+4,
// branch target, jump target and JR target. Redirects arriving while the
// hazard unit stalls are latched and applied when the stall releases.
// Ports:
//   Clk, Reset (async, active-low)
//   Stall                          - hold PC this cycle
//   BranchReq/BranchPC/BranchImm   - EX taken branch
//   JrReq/JrTarget                 - EX jump register
//   JumpReq/JumpPC/JumpIndex       - ID J/JAL
//   PC          - current fetch address
//   Flush       - combinational, clear IF/ID at this edge
//   Pending     - latched redirect awaiting stall release
//   RedirectSrc - source applied this cycle (0 none,1 branch,2 jr,3 jump)
//   RedirectCount - only with macro PC_REDIRECT_COUNT_EN: edges with Flush=1
module pc_redirect_controller
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchReq,
  input  logic [31:0]      BranchPC,
  input  logic [15:0]      BranchImm,
  input  logic             JrReq,
  input  logic [31:0]      JrTarget,
  input  logic             JumpReq,
  input  logic [31:0]      JumpPC,
  input  logic [25:0]      JumpIndex,
  output logic [31:0]      PC,
  output logic             Flush,
  output logic             Pending,
`ifdef PC_REDIRECT_COUNT_EN
  output logic [CNT_W-1:0] RedirectCount,
`endif
  output logic [1:0]       RedirectSrc
);

  state_t      state;
  logic [31:0] pend_target;
  logic [1:0]  pend_src;
  logic [31:0] seq_pc;
  logic [1:0]  live_src;
  logic [31:0] live_target;
  logic        outranks;
  logic [1:0]  apply_src;
  logic [31:0] apply_target;

  pc_target_calc u_calc (
    .pc          (PC),
    .branch_req  (BranchReq),
    .branch_pc   (BranchPC),
    .branch_imm  (BranchImm),
    .jr_req      (JrReq),
    .jr_target   (JrTarget),
    .jump_req    (JumpReq),
    .jump_pc     (JumpPC),
    .jump_index  (JumpIndex),
    .seq_pc      (seq_pc),
    .live_src    (live_src),
    .live_target (live_target)
  );

  // pend_src is SRC_NONE in RUN, so outranks then simply means "any request".
  assign outranks = src_rank(live_src) > src_rank(pend_src);

  always_comb begin
    apply_src    = SRC_NONE;
    apply_target = seq_pc;
    if (!Stall) begin
      if (state == PEND && !outranks) begin
        apply_src    = pend_src;
        apply_target = pend_target;
      end else if (live_src != SRC_NONE) begin
        apply_src    = live_src;
        apply_target = live_target;
      end
    end
  end

  assign Flush       = (apply_src != SRC_NONE);
  assign RedirectSrc = apply_src;
  assign Pending     = (state == PEND);

  // PC register, state and pending latch. While stalled, only a strictly
  // higher-priority request may replace what has been latched.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC          <= RESET_PC;
      state       <= RUN;
      pend_target <= 32'h0;
      pend_src    <= SRC_NONE;
    end else if (Stall) begin
      if (outranks) begin
        pend_target <= live_target;
        pend_src    <= live_src;
        state       <= PEND;
      end
    end else begin
      PC       <= apply_target;
      state    <= RUN;
      pend_src <= SRC_NONE;
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RedirectCount <= '0;
    end else if (Flush) begin
      RedirectCount <= RedirectCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_controller.sv
// tb_pc_redirect_controller
// Directed scenarios plus randomized traffic for pc_redirect_controller,
// checked against a queue-free behavioural model of the redirect rules.
// Build with PC_REDIRECT_COUNT_EN defined to also exercise RedirectCount.
module tb_pc_redirect_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        BranchReq;
  logic [31:0] BranchPC;
  logic [15:0] BranchImm;
  logic        JrReq;
  logic [31:0] JrTarget;
  logic        JumpReq;
  logic [31:0] JumpPC;
  logic [25:0] JumpIndex;
  logic [31:0] PC;
  logic        Flush;
  logic        Pending;
  logic [1:0]  RedirectSrc;
`ifdef PC_REDIRECT_COUNT_EN
  logic [31:0] RedirectCount;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: architectural PC plus the latched redirect, if any.
  logic [31:0] m_pc, m_ptgt, m_count;
  logic        m_pend;
  logic [1:0]  m_psrc;

  // Expectations for the current cycle and the state after the next edge.
  logic        e_flush;
  logic [1:0]  e_src;
  logic        e_pending;
  logic [31:0] e_pc_next, e_ptgt_next;
  logic        e_pend_next;
  logic [1:0]  e_psrc_next;

  always #5 Clk = ~Clk;

  pc_redirect_controller #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .BranchReq     (BranchReq),
    .BranchPC      (BranchPC),
    .BranchImm     (BranchImm),
    .JrReq         (JrReq),
    .JrTarget      (JrTarget),
    .JumpReq       (JumpReq),
    .JumpPC        (JumpPC),
    .JumpIndex     (JumpIndex),
    .PC            (PC),
    .Flush         (Flush),
    .Pending       (Pending),
`ifdef PC_REDIRECT_COUNT_EN
    .RedirectCount (RedirectCount),
`endif
    .RedirectSrc   (RedirectSrc)
  );

  task automatic resetModel();
    m_pc    = 32'h0;
    m_ptgt  = 32'h0;
    m_pend  = 1'b0;
    m_psrc  = 2'd0;
    m_count = 32'h0;
  endtask

  // Drives one cycle of inputs, works out what the controller must do with
  // them, then waits for the falling edge so outputs can be sampled.
  task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] bpc,
                               input logic [15:0] bimm, input logic jr, input logic [31:0] jrt,
                               input logic jq, input logic [31:0] jpc, input logic [25:0] jidx);
    logic [1:0]         live;
    logic [31:0]        ltgt;
    logic signed [31:0] off;
    logic               better;
    Stall = stall; BranchReq = br; BranchPC = bpc; BranchImm = bimm;
    JrReq = jr; JrTarget = jrt; JumpReq = jq; JumpPC = jpc; JumpIndex = jidx;
    off = $signed(bimm);
    live = 2'd0;
    ltgt = 32'h0;
    if (br) begin
      live = 2'd1; ltgt = bpc + off * 4;
    end else if (jr) begin
      live = 2'd2; ltgt = jrt;
    end else if (jq) begin
      live = 2'd3; ltgt = (jpc & 32'hF000_0000) | ({6'b0, jidx} * 4);
    end
    // Lower nonzero code = older instruction = higher priority.
    better = (live != 2'd0) && (!m_pend || live < m_psrc);
    e_pending   = m_pend;
    e_flush     = 1'b0;
    e_src       = 2'd0;
    e_pc_next   = m_pc;
    e_pend_next = m_pend;
    e_ptgt_next = m_ptgt;
    e_psrc_next = m_psrc;
    if (stall) begin
      if (better) begin
        e_pend_next = 1'b1; e_ptgt_next = ltgt; e_psrc_next = live;
      end
    end else begin
      e_pend_next = 1'b0;
      if (better) begin
        e_flush = 1'b1; e_src = live; e_pc_next = ltgt;
      end else if (m_pend) begin
        e_flush = 1'b1; e_src = m_psrc; e_pc_next = m_ptgt;
      end else begin
        e_pc_next = m_pc + 32'd4;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle(input logic stall);
    applyStimulus(stall, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0, 32'h0, 26'h0);
  endtask

  task automatic stepEdge();
    @(posedge Clk);
    #1;
    m_pc   = e_pc_next;
    m_pend = e_pend_next;
    m_ptgt = e_ptgt_next;
    m_psrc = e_psrc_next;
    if (e_flush) m_count = m_count + 32'd1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle(1'b0);
    resetModel();
    tests_run++;
    if (PC !== 32'h0 || Pending !== 1'b0 || Flush !== 1'b0 || RedirectSrc !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: PC=%h Pending=%b Flush=%b Src=%0d, want 0/0/0/0",
               PC, Pending, Flush, RedirectSrc);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      tests_run++;
      if (PC !== 32'(i * 4) || Flush !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL seq_after_reset[%0d]: PC=%h Flush=%b, want %h/0", i, PC, Flush, 32'(i * 4));
      end
      stepEdge();
    end
  endtask

  task automatic test_branch();
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 32'h100, 1'b0, 32'h0, 26'h0);
    tests_run++;
    if (Flush !== 1'b1 || RedirectSrc !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL jr_setup: Flush=%b Src=%0d, want 1/2", Flush, RedirectSrc);
    end
    stepEdge();
    applyStimulus(1'b0, 1'b1, 32'h104, 16'hFFFE, 1'b0, 32'h0, 1'b0, 32'h0, 26'h0);
    tests_run++;
    if (PC !== 32'h100 || Flush !== 1'b1 || RedirectSrc !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL branch_req: PC=%h Flush=%b Src=%0d, want 100/1/1", PC, Flush, RedirectSrc);
    end
    stepEdge();
    tests_run++;
    if (PC !== 32'h0000_00FC) begin
      tests_failed++;
      $display("[TB] FAIL branch_target: PC=%h, want 000000fc", PC);
    end
  endtask

  task automatic test_priority();
    applyStimulus(1'b0, 1'b1, 32'h300, 16'h0004, 1'b1, 32'h2000, 1'b1, 32'h4000_0008, 26'h10);
    tests_run++;
    if (RedirectSrc !== 2'd1 || Flush !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL priority_all: Src=%0d Flush=%b, want 1/1", RedirectSrc, Flush);
    end
    stepEdge();
    tests_run++;
    if (PC !== 32'h310) begin
      tests_failed++;
      $display("[TB] FAIL priority_target: PC=%h, want 00000310", PC);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b1, 32'h4000_0008, 26'h10);
    tests_run++;
    if (RedirectSrc !== 2'd3) begin
      tests_failed++;
      $display("[TB] FAIL jump_src: Src=%0d, want 3", RedirectSrc);
    end
    stepEdge();
    tests_run++;
    if (PC !== 32'h4000_0040) begin
      tests_failed++;
      $display("[TB] FAIL jump_target: PC=%h, want 40000040", PC);
    end
  endtask

  task automatic test_stall_overwrite();
    applyStimulus(1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 26'h10);
    tests_run++;
    if (Flush !== 1'b0 || Pending !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_jump: Flush=%b Pending=%b, want 0/0", Flush, Pending);
    end
    stepEdge();
    applyStimulus(1'b1, 1'b0, 32'h0, 16'h0, 1'b1, 32'h800, 1'b0, 32'h0, 26'h0);
    tests_run++;
    if (Pending !== 1'b1 || Flush !== 1'b0 || PC !== 32'h4000_0040) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: Pending=%b Flush=%b PC=%h, want 1/0/40000040", Pending, Flush, PC);
    end
    stepEdge();
    // A jump arriving now is lower priority and must not replace the jr.
    applyStimulus(1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b1, 32'h0, 26'h55);
    stepEdge();
    idle(1'b0);
    tests_run++;
    if (Flush !== 1'b1 || RedirectSrc !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL release_apply: Flush=%b Src=%0d, want 1/2", Flush, RedirectSrc);
    end
    stepEdge();
    idle(1'b0);
    tests_run++;
    if (PC !== 32'h800 || Pending !== 1'b0 || Flush !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release_target: PC=%h Pending=%b Flush=%b, want 800/0/0", PC, Pending, Flush);
    end
    stepEdge();
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b1, 32'h0, 26'h10);
    stepEdge();
    idle(1'b1);
    tests_run++;
    if (Pending !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pend_before_reset: Pending=%b, want 1", Pending);
    end
    stepEdge();
    Reset = 1'b0;
    #2;
    resetModel();
    tests_run++;
    if (PC !== 32'h0 || Pending !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_stall_reset: PC=%h Pending=%b, want 0/0", PC, Pending);
    end
    Reset = 1'b1;
    idle(1'b0);
    tests_run++;
    if (Flush !== 1'b0 || RedirectSrc !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL no_redirect_after_reset: Flush=%b Src=%0d, want 0/0", Flush, RedirectSrc);
    end
    stepEdge();
    tests_run++;
    if (PC !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL seq_after_mid_reset: PC=%h, want 00000004", PC);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 26'h0);
    stepEdge();
    idle(1'b0);
    stepEdge();
    tests_run++;
    if (PC !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL pc_wrap: PC=%h, want 00000000", PC);
    end
  endtask

  task automatic test_random();
    logic [25:0] ji;
    for (int i = 0; i < 400; i++) begin
      ji = 26'($urandom());
      applyStimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2), $urandom(),
                    16'($urandom()), ($urandom_range(0, 9) < 2), $urandom(),
                    ($urandom_range(0, 9) < 3), $urandom(), ji);
      tests_run++;
      if (Flush !== e_flush || RedirectSrc !== e_src || Pending !== e_pending || PC !== m_pc) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: Flush=%b Src=%0d Pending=%b PC=%h, want %b/%0d/%b/%h",
                 i, Flush, RedirectSrc, Pending, PC, e_flush, e_src, e_pending, m_pc);
      end
      stepEdge();
    end
    tests_run++;
    if (PC !== m_pc) begin
      tests_failed++;
      $display("[TB] FAIL random_final_pc: PC=%h, want %h", PC, m_pc);
    end
  endtask

`ifdef PC_REDIRECT_COUNT_EN
  task automatic test_count();
    Reset = 1'b0;
    #2;
    resetModel();
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 32'h40, 1'b0, 32'h0, 26'h0);
    stepEdge();
    idle(1'b0);
    stepEdge();
    applyStimulus(1'b0, 1'b1, 32'h48, 16'h0010, 1'b0, 32'h0, 1'b0, 32'h0, 26'h0);
    stepEdge();
    applyStimulus(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 32'h0, 1'b1, 32'h0, 26'h20);
    stepEdge();
    tests_run++;
    if (RedirectCount !== 32'd3 || m_count !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL redirect_count: count=%0d, want 3", RedirectCount);
    end
  endtask
`endif

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchReq = 1'b0; BranchPC = 32'h0; BranchImm = 16'h0;
    JrReq = 1'b0; JrTarget = 32'h0; JumpReq = 1'b0; JumpPC = 32'h0; JumpIndex = 26'h0;
    resetModel();
    test_reset();
    test_branch();
    test_priority();
    test_stall_overwrite();
    test_reset_mid_stall();
    test_wrap();
    test_random();
`ifdef PC_REDIRECT_COUNT_EN
    test_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
